// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential binary32 add/subtract unit.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 24;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    // Field positions inside a packed binary32 word.
    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int FRAC_HI  = 22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // Why a result was flagged; the port only exposes "any of these".
    typedef enum logic [1:0] {
        EXC_NONE,
        EXC_INPUT,
        EXC_OVERFLOW,
        EXC_UNDERFLOW
    } exc_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits a binary32 word into sign / exponent / mantissa with hidden bit and
// classifies it. Denormals are treated as exceptional, so a zero exponent
// with a non-zero fraction never reaches the datapath.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]          x,
    output logic                 sign,
    output logic [FP_EXP_W-1:0]  exp,
    output logic [FP_MANT_W-1:0] mant,
    output logic                 is_exc,
    output logic                 is_zero
);

    logic [FRAC_HI:0] frac;

    // Field split and classification.
    always_comb begin
        sign    = x[SIGN_BIT];
        exp     = x[EXP_HI:EXP_LO];
        frac    = x[FRAC_HI:0];
        mant    = {(exp != '0), frac};
        is_exc  = (exp == EXP_MAX) || ((exp == '0) && (frac != '0));
        is_zero = (exp == '0) && (frac == '0);
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle binary32 add/subtract: one shared datapath stepped through
// ALIGN, ADD, NORM and ROUND, result held in DONE until consumed.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int MAX_ALIGN = 25,
    parameter int MANT_W    = 24,
    parameter int EXP_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exception,
    output logic        busy
);

    localparam int XW    = EXP_W + 1;
    localparam int CNT_W = $clog2(MAX_ALIGN + 1);

    function automatic logic [MANT_W:0] round_half_up(input logic [MANT_W-1:0] m,
                                                      input logic g);
        return {1'b0, m} + {{MANT_W{1'b0}}, g};
    endfunction

    function automatic logic [31:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                         input logic [MANT_W-2:0] f);
        return {s, e, f};
    endfunction

    state_t state_q, state_n;
    exc_t   exc_q, exc_n;
    logic                 sign_q, sign_n;
    logic [XW-1:0]        exp_q, exp_n;
    logic [MANT_W-1:0]    mant_l_q, mant_l_n, mant_s_q, mant_s_n;
    logic                 guard_q, guard_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 eff_sub_q, eff_sub_n;
    logic [MANT_W:0]      sum_q, sum_n;
    logic [31:0]          result_q, result_n;

    logic                 a_sign, b_sign, a_exc, b_exc, a_zero, b_zero, a_ge;
    logic [EXP_W-1:0]     a_exp, b_exp, l_exp, s_exp, diff;
    logic [MANT_W-1:0]    a_mant, b_mant, l_mant, s_mant;
    logic [CNT_W-1:0]     cnt_load;
    logic [MANT_W:0]      rnd;
    logic [XW-1:0]        exp_r;
    logic [MANT_W-2:0]    frac_r;
    logic                 unused_zero_flags;

    // B's sign is inverted at accept for subtraction.
    fp_unpack u_unpack_a (
        .x       (op_a),
        .sign    (a_sign),
        .exp     (a_exp),
        .mant    (a_mant),
        .is_exc  (a_exc),
        .is_zero (a_zero)
    );

    fp_unpack u_unpack_b (
        .x       ({op_b[SIGN_BIT] ^ sub, op_b[EXP_HI:0]}),
        .sign    (b_sign),
        .exp     (b_exp),
        .mant    (b_mant),
        .is_exc  (b_exc),
        .is_zero (b_zero)
    );

    // Zero operands already carry a hidden bit of 0, so the flags need no action.
    assign unused_zero_flags = a_zero ^ b_zero;

    // Order operands by magnitude and derive the clamped alignment count.
    always_comb begin
        a_ge     = (op_a[EXP_HI:0] >= op_b[EXP_HI:0]);
        l_exp    = a_ge ? a_exp  : b_exp;
        s_exp    = a_ge ? b_exp  : a_exp;
        l_mant   = a_ge ? a_mant : b_mant;
        s_mant   = a_ge ? b_mant : a_mant;
        diff     = l_exp - s_exp;
        cnt_load = (diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : CNT_W'(diff);
    end

    // Next-state and datapath updates for every FSM step.
    always_comb begin
        state_n   = state_q;
        exc_n     = exc_q;
        sign_n    = sign_q;
        exp_n     = exp_q;
        mant_l_n  = mant_l_q;
        mant_s_n  = mant_s_q;
        guard_n   = guard_q;
        cnt_n     = cnt_q;
        eff_sub_n = eff_sub_q;
        sum_n     = sum_q;
        result_n  = result_q;
        rnd       = '0;
        exp_r     = '0;
        frac_r    = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    result_n = '0;
                    if (a_exc || b_exc) begin
                        exc_n   = EXC_INPUT;
                        state_n = S_DONE;
                    end else begin
                        exc_n     = EXC_NONE;
                        sign_n    = a_ge ? a_sign : b_sign;
                        exp_n     = {1'b0, l_exp};
                        mant_l_n  = l_mant;
                        mant_s_n  = s_mant;
                        guard_n   = 1'b0;
                        cnt_n     = cnt_load;
                        eff_sub_n = a_sign ^ b_sign;
                        state_n   = (cnt_load == '0) ? S_ADD : S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                mant_s_n = mant_s_q >> 1;
                guard_n  = mant_s_q[0];
                cnt_n    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_n = S_ADD;
            end
            S_ADD: begin
                sum_n   = eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                                    : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
                state_n = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    result_n = '0;
                    exc_n    = EXC_NONE;
                    state_n  = S_DONE;
                end else if (sum_q[MANT_W]) begin
                    sum_n   = sum_q >> 1;
                    guard_n = sum_q[0];
                    exp_n   = exp_q + XW'(1);
                    state_n = S_ROUND;
                end else if (sum_q[MANT_W-1]) begin
                    state_n = S_ROUND;
                end else if (exp_q <= XW'(1)) begin
                    result_n = '0;
                    exc_n    = EXC_UNDERFLOW;
                    state_n  = S_DONE;
                end else begin
                    sum_n   = {sum_q[MANT_W-1:0], guard_q};
                    guard_n = 1'b0;
                    exp_n   = exp_q - XW'(1);
                end
            end
            S_ROUND: begin
                rnd = round_half_up(sum_q[MANT_W-1:0], guard_q);
                if (rnd[MANT_W]) begin
                    frac_r = rnd[MANT_W-1:1];
                    exp_r  = exp_q + XW'(1);
                end else begin
                    frac_r = rnd[MANT_W-2:0];
                    exp_r  = exp_q;
                end
                if (exp_r >= XW'(EXP_MAX)) begin
                    result_n = '0;
                    exc_n    = EXC_OVERFLOW;
                end else begin
                    result_n = pack(sign_q, exp_r[EXP_W-1:0], frac_r);
                end
                state_n = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            exc_q     <= EXC_NONE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            guard_q   <= 1'b0;
            cnt_q     <= '0;
            eff_sub_q <= 1'b0;
            sum_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_n;
            exc_q     <= exc_n;
            sign_q    <= sign_n;
            exp_q     <= exp_n;
            mant_l_q  <= mant_l_n;
            mant_s_q  <= mant_s_n;
            guard_q   <= guard_n;
            cnt_q     <= cnt_n;
            eff_sub_q <= eff_sub_n;
            sum_q     <= sum_n;
            result_q  <= result_n;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign exception = (exc_q != EXC_NONE);

endmodule
